fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Instruction sequencer for the accumulator core. Owns the 10-bit PC and
//  fetches 16-bit words from instruction memory over a req/ack handshake.
//  Holds each word in the IR, which feeds the combinational decoder.
//  Samples the decoder's wrEnable/jmpEnable/branchEnable and gates all
//  register, flag and memory writes to a single EXEC cycle per instruction.
// PARAMETERS
//  ADDR_W       10   PC / imem address width
//  INSTR_W      16   instruction width; opcode = ir[15:10]
//  RESET_PC     0    PC value after reset
//  ACK_TIMEOUT  15   max cycles in FETCH without imem_ack before fault (>=1)
// PORTS
//  clk           in   1        single clock, rising edge
//  reset         in   1        asynchronous, active-high
//  run           in   1        1 = execute; 0 = stop at next instruction boundary
//  imem_req      out  1        fetch request
//  imem_addr     out  ADDR_W   fetch address (= pc)
//  imem_ack      in   1        fetch done; imem_data valid this cycle
//  imem_data     in   INSTR_W  fetched instruction
//  ir            out  INSTR_W  instruction register, to the decoder
//  ir_valid      out  1        high in DECODE and EXEC
//  wrEnable      in   1        decoder: store to data memory
//  jmpEnable     in   1        decoder: absolute jump
//  branchEnable  in   1        decoder: branch taken (flag test already applied)
//  exec_en       out  1        one-cycle strobe: load A/B/flags
//  mem_wr        out  1        exec_en & wrEnable
//  pc            out  ADDR_W   current PC
//  retired       out  16       retired-instruction count, wraps 0xFFFF->0
//  busy          out  1        state != IDLE/HALT
//  fault         out  1        sticky fetch-timeout flag
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, ir=0, retired=0, fault=0.
//   All strobes, imem_req, ir_valid and busy are 0.
//   Reset asserted mid-fetch drops imem_req immediately.
//  States: IDLE, FETCH, DECODE, EXEC, HALT.
//  IDLE   : run=1 -> FETCH.
//  FETCH  : imem_req=1, imem_addr=pc, both held stable until ack.
//   Ack -> ir<=imem_data, go to DECODE. Ack in the first FETCH cycle is legal.
//   Timeout counter is cleared on FETCH entry.
//   ACK_TIMEOUT cycles without ack -> fault<=1, go to HALT.
//  DECODE : one cycle for the decoder outputs to settle; no writes.
//  EXEC   : exec_en=1; mem_wr=wrEnable; retired++.
//   Next pc: jmpEnable -> ir[9:0];
//   else branchEnable -> pc+1+sext(ir[5:0]) mod 2^ADDR_W;
//   else pc+1 (1023 wraps to 0).
//   jmpEnable has priority over branchEnable if both are high.
//   Then run=1 -> FETCH, run=0 -> IDLE.
//  HALT   : every output inactive except fault=1 and pc frozen. Exits only on reset.
//  Latency: 3 cycles per instruction with zero-wait ack; +1 per wait cycle.
//  run deasserted in FETCH or DECODE: the current instruction completes.
//  imem_ack outside FETCH is ignored.
//  imem_data is sampled only on the ack cycle.
//  Decoder inputs are used only in EXEC.
// STRUCTURE
//  def.v (shared): state encodings, ADDR_W/INSTR_W defaults and the existing
//   opcode defines, so benches can assemble programs.
//  Sub-module pc_target_gen (combinational): pc, ir, jmpEnable,
//   branchEnable -> next pc, with the priority and wrap rules above.
//  Top level holds the FSM, the IR, the timeout counter and the retired counter.
// TESTING
//  1. Reset, run=1, zero-wait memory of NOPs -> imem_addr 0,1,2 every 3 cycles;
//     exec_en once per 3 cycles; retired=3 after 9 cycles.
//  2. JMP 0x3F0 at addr 5 -> the next fetch is at 0x3F0.
//     At pc=1023 with a non-jump instruction -> the next fetch is at 0.
//  3. Branch at pc=10: branchEnable=1, ir[5:0]=6'h3C (-4) -> next pc=7.
//     branchEnable=0 -> next pc=11.
//     jmpEnable and branchEnable both 1 -> the jmp target wins.
//  4. ack delayed 4 cycles -> imem_req/imem_addr stable for 5 cycles;
//     data sampled only on the ack cycle.
//     No ack for 15 cycles -> fault=1, HALT, imem_req=0, pc frozen.
//  5. STA in EXEC with wrEnable=1 -> mem_wr pulses for exactly 1 cycle.
//     wrEnable high during DECODE -> no mem_wr.
//  6. run dropped in the middle of FETCH -> the instruction retires, then IDLE.
//     Reset asserted in the middle of FETCH -> all outputs return to reset
//     values asynchronously, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the accumulator-core fetch sequencer: sequencer states,
// default widths and the opcode map used to assemble programs.
package fetch_sequencer_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_INSTR_W = 16;
    localparam int OPC_W       = 6;
    localparam int BR_OFF_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Opcode occupies ir[15:10]; the low 10 bits are an address or branch offset.
    localparam logic [OPC_W-1:0] OP_NOP  = 6'h00;
    localparam logic [OPC_W-1:0] OP_LDA  = 6'h01;
    localparam logic [OPC_W-1:0] OP_STA  = 6'h02;
    localparam logic [OPC_W-1:0] OP_ADD  = 6'h03;
    localparam logic [OPC_W-1:0] OP_SUB  = 6'h04;
    localparam logic [OPC_W-1:0] OP_JMP  = 6'h08;
    localparam logic [OPC_W-1:0] OP_BRZ  = 6'h09;
    localparam logic [OPC_W-1:0] OP_BRNZ = 6'h0A;

    function automatic logic [DEF_INSTR_W-1:0] assemble(input logic [OPC_W-1:0] op,
                                                        input logic [DEF_INSTR_W-OPC_W-1:0] field);
        return {op, field};
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_target_gen.sv
// Next-PC selection: absolute jump beats taken branch beats sequential;
// all arithmetic wraps modulo 2^ADDR_W.
module fetch_sequencer_pc_target_gen
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] ir_field,
    input  logic              jmpEnable,
    input  logic              branchEnable,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] br_off;

    assign seq_pc = pc + ADDR_W'(1);
    assign br_off = {{(ADDR_W-BR_OFF_W){ir_field[BR_OFF_W-1]}}, ir_field[BR_OFF_W-1:0]};

    always_comb begin
        next_pc = seq_pc;
        if (jmpEnable) begin
            next_pc = ir_field;
        end else if (branchEnable) begin
            next_pc = seq_pc + br_off;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction sequencer: fetches over req/ack, holds the IR for the decoder and
// opens a single EXEC cycle per instruction for all architectural writes.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int INSTR_W     = DEF_INSTR_W,
    parameter int RESET_PC    = 0,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               wrEnable,
    input  logic               jmpEnable,
    input  logic               branchEnable,
    output logic               exec_en,
    output logic               mem_wr,
    output logic [ADDR_W-1:0]  pc,
    output logic [15:0]        retired,
    output logic               busy,
    output logic               fault
);

    // Counter only needs to reach ACK_TIMEOUT-1; the timeout fires on that cycle.
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [INSTR_W-1:0] ir_reg, ir_next;
    logic [15:0]        retired_reg, retired_next;
    logic               fault_reg, fault_next;
    logic [TW-1:0]      tcnt_reg, tcnt_next;
    logic [ADDR_W-1:0]  target_pc;

    fetch_sequencer_pc_target_gen #(
        .ADDR_W(ADDR_W)
    ) u_target (
        .pc          (pc_reg),
        .ir_field    (ir_reg[ADDR_W-1:0]),
        .jmpEnable   (jmpEnable),
        .branchEnable(branchEnable),
        .next_pc     (target_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= RESET_PC_V;
            ir_reg      <= '0;
            retired_reg <= '0;
            fault_reg   <= 1'b0;
            tcnt_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            retired_reg <= retired_next;
            fault_reg   <= fault_next;
            tcnt_reg    <= tcnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        retired_next = retired_reg;
        fault_next   = fault_reg;
        tcnt_next    = tcnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (run) begin
                    state_next = ST_FETCH;
                    tcnt_next  = '0;
                end
            end
            ST_FETCH: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    ir_next    = imem_data;
                    state_next = ST_DECODE;
                end else if (tcnt_reg == TW'(ACK_TIMEOUT - 1)) begin
                    fault_next = 1'b1;
                    state_next = ST_HALT;
                end else begin
                    tcnt_next = tcnt_reg + TW'(1);
                end
            end
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                pc_next      = target_pc;
                retired_next = retired_reg + 16'd1;
                tcnt_next    = '0;
                state_next   = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    assign imem_req  = (state_reg == ST_FETCH);
    assign imem_addr = pc_reg;
    assign pc        = pc_reg;
    assign ir        = ir_reg;
    assign ir_valid  = (state_reg == ST_DECODE) || (state_reg == ST_EXEC);
    assign exec_en   = (state_reg == ST_EXEC);
    assign mem_wr    = exec_en & wrEnable;
    assign busy      = (state_reg == ST_FETCH) || (state_reg == ST_DECODE) || (state_reg == ST_EXEC);
    assign retired   = retired_reg;
    assign fault     = fault_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: acts as instruction memory and decoder, checks every
// cycle against a behavioural model, plus directed literal checks.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int ACK_TIMEOUT = 15;
    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_HALT = 4;

    logic        clk = 1'b0;
    logic        reset, run, imem_ack, wrEnable, jmpEnable, branchEnable;
    logic [15:0] imem_data;
    logic        imem_req, ir_valid, exec_en, mem_wr, busy, fault;
    logic [9:0]  imem_addr, pc;
    logic [15:0] ir, retired;

    fetch_sequencer #(
        .ADDR_W(10), .INSTR_W(16), .RESET_PC(0), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .ir(ir), .ir_valid(ir_valid),
        .wrEnable(wrEnable), .jmpEnable(jmpEnable), .branchEnable(branchEnable),
        .exec_en(exec_en), .mem_wr(mem_wr), .pc(pc), .retired(retired),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [1024];
    int n_checks = 0, n_fail = 0;
    int ack_mode, ack_delay, ecnt;
    bit rnd, both_flag;

    // Behavioural model of the sequencer as seen from its pins
    int m_phase, m_pc, m_ir, m_retired, m_fault, m_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 1024; i++) mem[i] = v;
    endtask

    task automatic at(input int k);
        while (ecnt < k) begin
            @(posedge clk);
            ecnt++;
        end
        #1;
    endtask

    task automatic hold_reset();
        @(posedge clk); #3;
        reset = 1'b1;
    endtask

    task automatic release_reset(input logic r);
        @(posedge clk); #3;
        reset = 1'b0;
        run   = r;
        ecnt  = 0;
    endtask

    // Driver + model + per-cycle comparison, all on the falling edge
    initial begin : drv
        logic [5:0] op;
        logic zf, ack_now;
        int off;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_phase = P_IDLE; m_pc = 0; m_ir = 0; m_retired = 0; m_fault = 0; m_wait = 0;
            end
            if (m_phase == P_FETCH) begin
                case (ack_mode)
                    0: ack_now = ($urandom_range(0, 2) != 0);
                    1: ack_now = (m_wait == ack_delay);
                    default: ack_now = 1'b0;
                endcase
            end else begin
                ack_now = 1'($urandom);
            end
            imem_ack  = ack_now;
            imem_data = (m_phase == P_FETCH && ack_now) ? mem[m_pc] : 16'($urandom);
            if (m_phase == P_EXEC) begin
                op = m_ir[15:10];
                zf = rnd ? 1'($urandom) : 1'b1;
                wrEnable     = (op == OP_STA);
                jmpEnable    = (op == OP_JMP);
                branchEnable = (op == OP_BRZ && zf) || (op == OP_BRNZ && !zf) ||
                               (op == OP_JMP && (rnd ? 1'($urandom) : both_flag));
            end else if (rnd) begin
                wrEnable = 1'($urandom); jmpEnable = 1'($urandom); branchEnable = 1'($urandom);
            end else begin
                wrEnable = 1'b1; jmpEnable = 1'b1; branchEnable = 1'b1;
            end
            #1;
            check("imem_req", imem_req, m_phase == P_FETCH);
            check("imem_addr", imem_addr, m_pc);
            check("pc", pc, m_pc);
            check("ir", ir, m_ir);
            check("ir_valid", ir_valid, m_phase == P_DECODE || m_phase == P_EXEC);
            check("exec_en", exec_en, m_phase == P_EXEC);
            check("mem_wr", mem_wr, m_phase == P_EXEC && wrEnable);
            check("retired", retired, m_retired);
            check("busy", busy, m_phase == P_FETCH || m_phase == P_DECODE || m_phase == P_EXEC);
            check("fault", fault, m_fault);
            if (!reset) begin
                case (m_phase)
                    P_IDLE: if (run) begin m_phase = P_FETCH; m_wait = 0; end
                    P_FETCH: begin
                        if (imem_ack) begin
                            m_ir = int'(imem_data);
                            m_phase = P_DECODE;
                        end else begin
                            m_wait++;
                            if (m_wait >= ACK_TIMEOUT) begin m_fault = 1; m_phase = P_HALT; end
                        end
                    end
                    P_DECODE: m_phase = P_EXEC;
                    P_EXEC: begin
                        m_retired = (m_retired + 1) % 65536;
                        if (jmpEnable) m_pc = m_ir % 1024;
                        else if (branchEnable) begin
                            off = m_ir % 64;
                            if (off >= 32) off -= 64;
                            m_pc = (m_pc + 1 + off + 1024) % 1024;
                        end else m_pc = (m_pc + 1) % 1024;
                        m_phase = run ? P_FETCH : P_IDLE;
                        m_wait = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    initial begin
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = '0;
        wrEnable = 1'b0; jmpEnable = 1'b0; branchEnable = 1'b0;
        ack_mode = 1; ack_delay = 0; rnd = 1'b0; both_flag = 1'b0; ecnt = 0;
        fill(assemble(OP_NOP, 10'h000));

        // 1: zero-wait NOP stream, 3 cycles per instruction
        repeat (2) @(posedge clk);
        release_reset(1'b1);
        at(1);  check("s1_addr0", imem_addr, 0); check("s1_req", imem_req, 1);
        at(4);  check("s1_addr1", imem_addr, 1);
        at(7);  check("s1_addr2", imem_addr, 2);
        at(10); check("s1_retired3", retired, 3); check("s1_model_retired", m_retired, 3);

        // 2: absolute jump and wrap at the top of memory
        hold_reset();
        fill(assemble(OP_NOP, 10'h000));
        mem[5] = assemble(OP_JMP, 10'h3F0);
        release_reset(1'b1);
        at(19); check("s2_jmp_target", imem_addr, 10'h3F0); check("s2_model_pc", m_pc, 10'h3F0);
        at(64); check("s2_addr_3ff", imem_addr, 10'h3FF);
        at(67); check("s2_wrap0", imem_addr, 0);

        // 3: branch taken / not taken, jump priority over branch
        hold_reset();
        fill(assemble(OP_NOP, 10'h000));
        both_flag = 1'b1;
        mem[0]  = assemble(OP_JMP, 10'd10);
        mem[10] = assemble(OP_BRZ, 10'h03C);
        mem[7]  = assemble(OP_JMP, 10'd20);
        mem[20] = assemble(OP_BRNZ, 10'h03C);
        mem[21] = assemble(OP_JMP, 10'h105);
        release_reset(1'b1);
        at(4);  check("s3_at10", imem_addr, 10);
        at(7);  check("s3_br_taken", imem_addr, 7);
        at(13); check("s3_br_not_taken", imem_addr, 21);
        at(16); check("s3_jmp_wins", imem_addr, 10'h105);
        both_flag = 1'b0;

        // 4a: four wait cycles before ack
        hold_reset();
        fill(assemble(OP_ADD, 10'h155));
        ack_delay = 4;
        release_reset(1'b1);
        for (int k = 1; k <= 5; k++) begin
            at(k);
            check("s4_req_hold", imem_req, 1);
            check("s4_addr_hold", imem_addr, 0);
        end
        at(6); check("s4_decode", ir_valid, 1); check("s4_ir", ir, 16'h0D55); check("s4_req_drop", imem_req, 0);

        // 4b: fetch timeout after a couple of instructions
        hold_reset();
        ack_delay = 0;
        release_reset(1'b1);
        at(5); #2; ack_mode = 2;
        at(21); check("s4_no_fault_yet", fault, 0); check("s4_req_waiting", imem_req, 1);
        at(22); check("s4_fault", fault, 1); check("s4_halt_req", imem_req, 0);
        check("s4_halt_busy", busy, 0); check("s4_pc_frozen", pc, 2);
        at(30); check("s4_still_halted", fault, 1); check("s4_pc_still", pc, 2);

        // 5: store strobe gated to EXEC
        hold_reset();
        ack_mode = 1; ack_delay = 0;
        fill(assemble(OP_ADD, 10'h155));
        mem[0] = assemble(OP_STA, 10'h02A);
        release_reset(1'b1);
        at(2); #5; check("s5_decode_no_wr", mem_wr, 0);
        at(3); #5; check("s5_exec_wr", mem_wr, 1);
        at(4); #5; check("s5_after_wr", mem_wr, 0);
        at(6); #5; check("s5_add_no_wr", mem_wr, 0);

        // 6: run dropped mid-fetch, then reset mid-fetch
        hold_reset();
        ack_delay = 3;
        release_reset(1'b1);
        at(2); #2; run = 1'b0;
        at(7); check("s6_idle_busy", busy, 0); check("s6_retired1", retired, 1);
        check("s6_pc1", pc, 1); check("s6_idle_req", imem_req, 0);
        at(9); check("s6_stays_idle", imem_req, 0);
        #2; run = 1'b1;
        at(11); check("s6_fetching", imem_req, 1);
        #2; reset = 1'b1; #1;
        check("s6_rst_req", imem_req, 0); check("s6_rst_pc", pc, 0);
        check("s6_rst_retired", retired, 0); check("s6_rst_ir", ir, 0); check("s6_rst_busy", busy, 0);

        // Randomised program, memory timing, decoder flags and run
        fill(16'h0000);
        for (int i = 0; i < 1024; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: mem[i] = assemble(OP_ADD, 10'($urandom));
                3:       mem[i] = assemble(OP_STA, 10'($urandom));
                4:       mem[i] = assemble(OP_JMP, 10'($urandom));
                5, 6:    mem[i] = assemble(OP_BRZ, 10'($urandom));
                7:       mem[i] = assemble(OP_BRNZ, 10'($urandom));
                default: mem[i] = 16'($urandom);
            endcase
        end
        rnd = 1'b1; ack_mode = 0;
        release_reset(1'b1);
        for (int k = 1; k <= 4000; k++) begin
            at(k);
            #2;
            run = ($urandom_range(0, 7) != 0);
        end
        at(4002);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
